// File: rtl/polyvecl_chknorm_pkg.sv
//------------------------------------------------------------------------------
// Module   : polyvecl_chknorm_pkg
// Brief    : Shared ring/vector constants and FSM state type for the vector
//            datapath (poly_add, polyvecl_add, polyvecl_chknorm).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package polyvecl_chknorm_pkg;

    localparam int Q           = 8380417;
    localparam int N           = 256;
    localparam int L           = 5;
    localparam int K           = 6;
    localparam int W           = 32;
    localparam int POLY_BITS   = N * W;
    localparam int VEC_BITS    = L * POLY_BITS;

    // Largest bound for which the norm check is meaningful.
    localparam logic [W-1:0] BOUND_LIMIT = W'((Q - 1) / 8);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/polyvecl_chknorm_if.sv
//------------------------------------------------------------------------------
// Module   : polyvecl_chknorm_if
// Brief    : start/busy/done handshake plus vector and bound for the checker.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface polyvecl_chknorm_if;
    import polyvecl_chknorm_pkg::*;

    logic                start;
    logic [VEC_BITS-1:0] v_in;
    logic [W-1:0]        bound;
    logic                busy;
    logic                done;
    logic                fail;

    modport master (
        output start, v_in, bound,
        input  busy, done, fail
    );

    modport slave (
        input  start, v_in, bound,
        output busy, done, fail
    );
endinterface

`default_nettype wire

// File: rtl/polyvecl_chknorm_coeff_chknorm.sv
//------------------------------------------------------------------------------
// Module   : coeff_chknorm
// Brief    : Combinational |coeff| >= bound test for one signed coefficient.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module coeff_chknorm #(
    parameter int W = 32
) (
    input  wire logic [W-1:0] coeff,
    input  wire logic [W-1:0] bound,
    output logic              violate
);

    logic [W:0] w_ext;
    logic [W:0] w_abs;

    // One extra bit so that the most negative value negates to +2^(W-1).
    assign w_ext   = {coeff[W-1], coeff};
    assign w_abs   = coeff[W-1] ? (~w_ext + (W+1)'(1)) : w_ext;
    assign violate = (w_abs >= {1'b0, bound});

endmodule

`default_nettype wire

// File: rtl/polyvecl_chknorm.sv
//------------------------------------------------------------------------------
// Module   : polyvecl_chknorm
// Brief    : Sequential infinity-norm check of an L-poly vector, P lanes/cycle,
//            with early exit on the first violating group.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module polyvecl_chknorm
    import polyvecl_chknorm_pkg::*;
#(
    parameter int P = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    polyvecl_chknorm_if.slave bus
);

    localparam int c_groups = (L * N) / P;
    localparam int c_gw     = (c_groups > 1) ? $clog2(c_groups) : 1;
    localparam logic [c_gw-1:0] c_last = c_gw'(c_groups - 1);

    state_t              r_state;
    logic [VEC_BITS-1:0] r_vec;
    logic [W-1:0]        r_bound;
    logic [c_gw-1:0]     r_group;
    logic                r_busy;
    logic                r_done;
    logic                r_fail;

    logic [P-1:0]        w_lane_violate;
    logic                w_any_violate;

    // The current group always sits in the low P*W bits; the vector is shifted
    // down once per scanned group instead of muxing a wide part-select.
    generate
        for (genvar j = 0; j < P; j++) begin : g_lane
            coeff_chknorm #(.W(W)) u_chk (
                .coeff   (r_vec[j*W +: W]),
                .bound   (r_bound),
                .violate (w_lane_violate[j])
            );
        end
    endgenerate

    assign w_any_violate = |w_lane_violate;

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && bus.start) begin
            r_vec   <= bus.v_in;
            r_bound <= bus.bound;
        end else if (r_state == S_SCAN) begin
            r_vec   <= r_vec >> (P * W);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_group <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_fail  <= 1'b0;
                        r_group <= '0;
                        if (bus.bound > BOUND_LIMIT) begin
                            r_done <= 1'b1;
                            r_fail <= 1'b1;
                        end else begin
                            r_state <= S_SCAN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    if (w_any_violate) begin
                        r_done  <= 1'b1;
                        r_fail  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_group == c_last) begin
                        r_done  <= 1'b1;
                        r_fail  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_group <= r_group + c_gw'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.fail = r_fail;

endmodule

`default_nettype wire
